// File: rtl/seq_alu.sv
// seq_alu: registered ALU with start/done handshake, multi-cycle shifts and shift-add multiply
module seq_alu #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  carry,
  output logic                  overflow,
  output logic                  zero,
  output logic                  negative,
  output logic                  illegal,
  output logic                  busy,
  output logic                  done
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, FIN = 2'd2;
  localparam logic [CNT_WIDTH-1:0] W_CNT = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] W_VAL = DATA_WIDTH'(DATA_WIDTH);
  localparam int M = DATA_WIDTH - 1;

  logic [1:0]            state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, acc_q, acc_d, b_q, b_d, out_q, out_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d, ill_q, ill_d, done_q, done_d;
  logic [DATA_WIDTH:0]   sum, diff, mul_sum;
  logic [DATA_WIDTH-1:0] one_res, step_acc, step_b, step_res, res;
  logic one_c, one_v, multi, step_c, step_v, wr, res_c, res_v, res_il;

  assign out      = out_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign illegal  = ill_q;
  assign busy     = state_q == EXEC;
  assign done     = done_q;

  // single-cycle result and flags taken straight from the input operands
  always_comb begin
    sum     = {1'b0, in1} + {1'b0, in2};
    diff    = {1'b0, in1} - {1'b0, in2};
    multi   = op == 4'd7 || op == 4'd8 || op == 4'd9;
    one_res = op == 4'd0 ? sum[M:0] :
              op == 4'd1 ? diff[M:0] :
              op == 4'd2 ? in1 & in2 :
              op == 4'd3 ? in1 | in2 :
              op == 4'd4 ? in1 ^ in2 :
              op == 4'd5 ? ~in1 : '0;
    one_c   = op == 4'd0 ? sum[DATA_WIDTH] : op == 4'd1 ? diff[DATA_WIDTH] : 1'b0;
    one_v   = op == 4'd0 ? (in1[M] == in2[M]) && (sum[M] != in1[M]) :
              op == 4'd1 ? (in1[M] != in2[M]) && (diff[M] != in1[M]) : 1'b0;
  end

  // one iteration of the active multi-cycle op; MUL keeps the product as {acc, b}
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);
    step_acc = op_q == 4'd7 ? {acc_q[M-1:0], 1'b0} :
               op_q == 4'd8 ? {1'b0, acc_q[M:1]} : mul_sum[DATA_WIDTH:1];
    step_b   = op_q == 4'd9 ? {mul_sum[0], b_q[M:1]} : b_q;
    step_res = op_q == 4'd9 ? step_b : step_acc;
    step_c   = op_q == 4'd7 ? acc_q[M] : op_q == 4'd8 ? acc_q[0] : 1'b0;
    step_v   = op_q == 4'd9 && step_acc != '0;
  end

  // handshake sequencing, datapath advance and result capture
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    acc_d   = acc_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    wr      = 1'b0;
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_il  = 1'b0;
    if (start && state_q != EXEC) begin
      op_d  = op;
      a_d   = in1;
      b_d   = in2;
      acc_d = op == 4'd9 ? '0 : in1;
      cnt_d = op == 4'd9 ? W_CNT : in2 >= W_VAL ? W_CNT : in2[CNT_WIDTH-1:0];
      if (multi && cnt_d != '0) begin
        state_d = EXEC;
      end else begin
        state_d = IDLE;
        wr      = 1'b1;
        res     = multi ? in1 : one_res;
        res_c   = multi ? 1'b0 : one_c;
        res_v   = multi ? 1'b0 : one_v;
        res_il  = op >= 4'd10;
      end
    end else if (state_q == EXEC) begin
      acc_d = step_acc;
      b_d   = step_b;
      cnt_d = cnt_q - CNT_WIDTH'(1);
      if (cnt_q == CNT_WIDTH'(1)) begin
        state_d = FIN;
        wr      = 1'b1;
        res     = step_res;
        res_c   = step_c;
        res_v   = step_v;
      end
    end else if (state_q == FIN) begin
      state_d = IDLE;
    end
    out_d   = wr ? res : out_q;
    carry_d = wr ? res_c : carry_q;
    ovf_d   = wr ? res_v : ovf_q;
    zero_d  = wr ? res == '0 : zero_q;
    neg_d   = wr ? res[M] : neg_q;
    ill_d   = wr ? res_il : ill_q;
    done_d  = wr;
  end

  // state and result registers, cleared asynchronously by an active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ill_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ill_q   <= ill_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered ALU with a start/busy/done handshake, full-width logic ops and status flags.
- Adds multi-cycle iterative operations: bit-serial shifts and a shift-add multiplier.
- Sits between the register file and the write-back path.
- Replaces the purely combinational ALU, whose logic ops were only 4 bits wide.

Parameters:
DATA_WIDTH, 8, operand/result width (>=4)
CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  begin operation; sampled only while busy=0
op  input  4  opcode, latched with start
in1  input  DATA_WIDTH  operand A, latched with start
in2  input  DATA_WIDTH  operand B / shift amount, latched with start
out  output  DATA_WIDTH  registered result
carry  output  1  carry/borrow/last bit shifted out
overflow  output  1  signed overflow (ADD/SUB); nonzero high half (MUL)
zero  output  1  out==0
negative  output  1  out[DATA_WIDTH-1]
illegal  output  1  last op was an undefined opcode
busy  output  1  operation in progress
done  output  1  one-cycle pulse when results are valid

Behaviour:
- Reset (reset=0, async): state=IDLE; out, all flags, busy, done, and the internal accumulator and counter are 0. Reset mid-operation aborts the operation, and no done is issued.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INV (~A), 6 CLR, 7 SHL, 8 SHR (logical), 9 MUL (unsigned, low half). 10-15 are illegal.
- FSM states: IDLE, EXEC, FIN.
- IDLE, start=1 (ops 0-6 and illegal):
  - Result and flags register at the next edge; done=1 for that one cycle; state stays IDLE.
  - Latency is 1 cycle and busy stays 0.
- IDLE, start=1 (ops 7-9):
  - Latch operands and go to EXEC; busy=1 from the next cycle.
  - Shift count s=min(in2, DATA_WIDTH); MUL count = DATA_WIDTH.
- EXEC:
  - One shift or one add-shift step per cycle; counter decrements.
  - When the counter reaches 0, go to FIN. For s=0, EXEC is passed through with no step.
- FIN: registers out and flags; done=1 and busy=0 in the same cycle; go to IDLE.
- Latency from the start edge to the done cycle:
  - shift: s+1 cycles (s=0 gives 1);
  - MUL: DATA_WIDTH+1 cycles.
- start while busy=1 is ignored, with no queuing. start is accepted again in the cycle done=1 appears (IDLE).
- Flags:
  - ADD: carry = carry out of the MSB; overflow = signed overflow.
  - SUB: A-B; carry = borrow (A<B unsigned); overflow = signed overflow.
  - AND/OR/XOR/INV/CLR: carry = 0, overflow = 0.
  - SHL/SHR: carry = last bit shifted out (0 if s=0); overflow = 0.
  - MUL: 2*DATA_WIDTH-bit product; out = low half; overflow = (high half != 0); carry = 0.
  - zero and negative are computed on the final out for every op.
  - illegal = 1 only for opcodes 10-15, which also give out=0 and all other flags 0 except zero=1.
- Between operations, out and all flags hold their last values. done is never high for more than one cycle.

Test Plan:
- ADD in1=0xF0, in2=0x20 -> next cycle: out=0x10, carry=1, overflow=0, done=1, busy stays 0.
- SUB in1=0x80, in2=0x01 -> out=0x7F, carry=0, overflow=1, negative=0. Then SUB 0x01-0x02 -> out=0xFF, carry=1, negative=1.
- SHL in1=0x81, in2=3 -> busy=1 for cycles 1-3, done at cycle 4 with out=0x08, carry=0. SHR 0x81 by 1 -> out=0x40, carry=1. SHL by in2=20 -> out=0x00, zero=1 after 9 cycles.
- MUL 0x10*0x11 with an extra start pulse at cycle 3 -> done only at cycle 9: out=0x10, overflow=1; the extra start is ignored (single done). MUL 0x0F*0x11 -> out=0xFF, overflow=0.
- Reset pulled low at cycle 4 of a MUL -> out, flags and busy go to 0 immediately, no done follows; after release, ADD 1+1 -> out=0x02.
- op=12 -> next cycle: illegal=1, out=0, zero=1, done=1; a following AND 0xF0&0x3C -> out=0x30, illegal=0.
